calc_arbiter: RTL and testbench
===============================

# calc_arbiter

Sequencing front end for the 4-bit calculator ALU (`calculator`: 4-bit A/B, 2-bit Op, 5-bit Result). It accepts operation requests from two independent requester ports using valid/ready handshakes and grants the single ALU instance to one requester at a time, round-robin. It holds the operands stable for a configurable number of execute cycles, then returns the 5-bit result with the requester ID through a response handshake. It sits between the control/sequencing logic and the shared `calculator` datapath, which it instantiates internally.

## Interface
- `EXEC_CYCLES`, default 1: cycles spent in EXEC with latched operands on the ALU; legal range 1..15.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  port 0 request valid.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `req0_a`, `req0_b`  in  4 each  port 0 operands.
- `req0_op`  in  2  port 0 opcode: 00 add, 01 sub, 10 AND, 11 OR.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as port 0, for port 1.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester index of the response.
- `rsp_result`  out  5  ALU result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If either `reqN_valid` is high, the arbiter picks a winner and asserts that port's `reqN_ready` combinationally in the same cycle.
  - The winner's A, B, Op and ID are latched.
  - The execute counter loads `EXEC_CYCLES-1`, and the FSM moves to EXEC.
- **EXEC:**
  - The latched operands drive the `calculator` instance.
  - The counter decrements each cycle.
  - When the counter reaches 0, the ALU `Result` is registered into `rsp_result`/`rsp_id`, and the FSM moves to RESP.
- **RESP:**
  - `rsp_valid` is high, and `rsp_result`/`rsp_id` are held stable.
  - When `rsp_ready` is high, the FSM moves to IDLE.
- **Round-robin arbitration:**
  - A `last_grant` register records the last winner.
  - When both ports are valid, the port not equal to `last_grant` wins.
  - When only one port is valid, that port wins.
  - `last_grant` updates on every accept.
- **Requester and response rules:**
  - A requester must hold valid and operands until it sees ready. Dropping valid before ready is legal; no request is taken.
  - `reqN_ready` is never high outside IDLE, and never high for both ports in the same cycle.
- **Arithmetic** (5-bit result, computed by `calculator`):
  - Add: zero-extended sum, e.g. F+F=5'h1E.
  - Sub: modulo 32, e.g. 3-5=5'h1E.
  - AND/OR: bit 4 = 0.
- **Reset values:**
  - FSM = IDLE; `last_grant` = 1, so port 0 has first priority.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0, `busy`=0.
  - `req0_ready` and `req1_ready` are low during reset.
- **Reset mid-operation:** aborts the in-flight operation with no response, and all state returns to reset values.

## Timing
- Request accepted at edge N (valid and ready both high in cycle N-1→N window, i.e. the handshake cycle).
- FSM in EXEC for `EXEC_CYCLES` cycles; `rsp_valid` rises `EXEC_CYCLES` cycles after the accept edge.
- With `rsp_ready` tied high:
  - RESP lasts 1 cycle.
  - Minimum spacing between accepts is `EXEC_CYCLES`+2 cycles.
- Backpressure: RESP holds indefinitely while `rsp_ready`=0, and no new request is accepted.
- A request arriving while busy waits and is accepted in the first IDLE cycle.

## Configuration
- **`CALC_ARB_FIXED_PRIO_EN` defined:**
  - Arbitration is fixed priority, with port 0 always winning when both ports are valid.
  - `last_grant` is not implemented.
- **`CALC_ARB_FIXED_PRIO_EN` undefined:** round-robin arbitration as described in Operation.

## Test plan
- **Reset defaults:** assert `rst` 2 cycles with both valids high.
  - Every output is 0 during reset.
  - The first accept after reset goes to port 0.
- **Single op, `EXEC_CYCLES`=1, `rsp_ready`=1:** port 0 sends A=9, B=8, Op=00.
  - `rsp_valid` is high 1 cycle after accept, with `rsp_result`=5'h11 and `rsp_id`=0.
  - `busy` is low the following cycle.
- **Contention:** both ports continuously valid; port 0 Op=01 A=3 B=5, port 1 Op=11 A=A B=5.
  - Responses alternate id 0,1,0,1.
  - Results alternate 5'h1E, 5'h0F.
  - With `CALC_ARB_FIXED_PRIO_EN` defined, all responses have id 0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP while port 1 is valid.
  - `rsp_result`/`rsp_id` stay stable.
  - `req1_ready` stays 0.
  - Port 1 is accepted in the cycle after `rsp_ready` handshake returns the FSM to IDLE.
- **`EXEC_CYCLES`=4:** Op=10 A=C B=A.
  - `rsp_valid` rises 4 cycles after accept, with result 5'h08.
- **Reset mid-EXEC:** assert `rst` during EXEC.
  - No response is produced.
  - `busy`=0 after reset.
  - A subsequent request completes normally.

Source files
------------

// File: rtl/calc_arbiter_if.sv
// calc_arbiter_if: request/response bundle between requesters, the response
// consumer and calc_arbiter.
//
// Handshake rule (all channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and payload
// stable until that edge. It may drop valid before ready is seen, and then
// nothing is transferred. Ready may depend combinationally on valid.
interface calc_arbiter_if;
  // requester port 0
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [1:0] req0_op;
  // requester port 1
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [1:0] req1_op;
  // response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [4:0] rsp_result;
  // status
  logic       busy;

  // requester/consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, busy
  );

  // arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/calc_arbiter.sv
// calc_arbiter: two-port front end for the shared 4-bit calculator ALU.
// One request is granted at a time (round-robin), its operands are held on
// the ALU for EXEC_CYCLES cycles, then the result is returned with the
// requester id through the response handshake.
//
// Build option: define CALC_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (port 0 wins when both ports are valid).
//
// Also contains `calculator`, the 4-bit ALU datapath instantiated here.

// calculator: 4-bit ALU with a 5-bit result.
//   Op 00: A + B, zero-extended (carry lands in bit 4)
//   Op 01: A - B modulo 32
//   Op 10: A & B, bit 4 = 0
//   Op 11: A | B, bit 4 = 0
module calculator (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] Op,
  output logic [4:0] Result
);
  // pure combinational datapath
  always_comb begin
    Result = 5'd0;
    unique case (Op)
      2'b00:   Result = {1'b0, A} + {1'b0, B};
      2'b01:   Result = {1'b0, A} - {1'b0, B};
      2'b10:   Result = {1'b0, A & B};
      default: Result = {1'b0, A | B};
    endcase
  end
endmodule

module calc_arbiter #(
  // cycles spent in EXEC with the latched operands on the ALU (1..15)
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  calc_arbiter_if.slave bus,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter runs from EXEC_CYCLES-1 down to 0, so EXEC lasts exactly
  // EXEC_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;

  logic [3:0] cnt_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] op_q;
  logic       id_q;

  logic [4:0] alu_result;
  logic [4:0] rsp_result_q;
  logic       rsp_id_q;

  logic       any_valid;
  logic       win_id;
  logic       accept;
  logic       exec_done;

`ifndef CALC_ARB_FIXED_PRIO_EN
  // Last granted port; resets to 1 so port 0 gets the first tie.
  logic       last_grant_q;
`endif

  assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef CALC_ARB_FIXED_PRIO_EN
  // Fixed priority: port 1 only wins when port 0 is not asking.
  always_comb begin
    win_id = ~bus.req0_valid;
  end
`else
  // Round-robin: on a tie the port that did not win last time goes first.
  always_comb begin
    win_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      win_id = ~last_grant_q;
    end else if (bus.req1_valid) begin
      win_id = 1'b1;
    end
  end
`endif

  // Grant only in IDLE and never while reset is held. The winner is decided
  // in the same cycle, so at most one ready is high.
  assign accept         = (state_q == IDLE) && any_valid && !rst;
  assign bus.req0_ready = accept && !win_id;
  assign bus.req1_ready = accept && win_id;

  assign exec_done = (state_q == EXEC) && (cnt_q == 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request so the ALU inputs stay stable through EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= 4'd0;
      b_q  <= 4'd0;
      op_q <= 2'd0;
      id_q <= 1'b0;
    end else if (accept) begin
      a_q  <= win_id ? bus.req1_a  : bus.req0_a;
      b_q  <= win_id ? bus.req1_b  : bus.req0_b;
      op_q <= win_id ? bus.req1_op : bus.req0_op;
      id_q <= win_id;
    end
  end

`ifndef CALC_ARB_FIXED_PRIO_EN
  // Remember who won so the next tie goes to the other port
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= win_id;
    end
  end
`endif

  // Execute counter: loaded on accept, counts down while in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= CNT_LOAD;
    end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  calculator u_alu (
    .A      (a_q),
    .B      (b_q),
    .Op     (op_q),
    .Result (alu_result)
  );

  // Capture the ALU result on the last EXEC cycle; held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result_q <= 5'd0;
      rsp_id_q     <= 1'b0;
    end else if (exec_done) begin
      rsp_result_q <= alu_result;
      rsp_id_q     <= id_q;
    end
  end

  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = (state_q != IDLE);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: drives two calc_arbiter instances (EXEC_CYCLES = 1 and 4)
// with directed and randomized traffic. A transaction-level reference model
// predicts grants, busy, response timing and response payloads.
module tb_calc_arbiter;

  localparam int EX_K0 = 1;
  localparam int EX_K1 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  calc_arbiter_if if_k0 ();
  calc_arbiter_if if_k1 ();
  logic [1:0] dbg_k0;
  logic [1:0] dbg_k1;

  calc_arbiter #(.EXEC_CYCLES(EX_K0)) dut_k0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if_k0),
    .state_dbg (dbg_k0)
  );

  calc_arbiter #(.EXEC_CYCLES(EX_K1)) dut_k1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if_k1),
    .state_dbg (dbg_k1)
  );

  // ---------------- stimulus variables (index = DUT) ----------------
  logic       d_v0 [2];
  logic       d_v1 [2];
  logic [3:0] d_a0 [2];
  logic [3:0] d_b0 [2];
  logic [1:0] d_op0 [2];
  logic [3:0] d_a1 [2];
  logic [3:0] d_b1 [2];
  logic [1:0] d_op1 [2];
  logic       d_rr [2];

  assign if_k0.req0_valid = d_v0[0];
  assign if_k0.req0_a     = d_a0[0];
  assign if_k0.req0_b     = d_b0[0];
  assign if_k0.req0_op    = d_op0[0];
  assign if_k0.req1_valid = d_v1[0];
  assign if_k0.req1_a     = d_a1[0];
  assign if_k0.req1_b     = d_b1[0];
  assign if_k0.req1_op    = d_op1[0];
  assign if_k0.rsp_ready  = d_rr[0];
  assign if_k1.req0_valid = d_v0[1];
  assign if_k1.req0_a     = d_a0[1];
  assign if_k1.req0_b     = d_b0[1];
  assign if_k1.req0_op    = d_op0[1];
  assign if_k1.req1_valid = d_v1[1];
  assign if_k1.req1_a     = d_a1[1];
  assign if_k1.req1_b     = d_b1[1];
  assign if_k1.req1_op    = d_op1[1];
  assign if_k1.rsp_ready  = d_rr[1];

  // observed outputs
  logic       o_r0 [2];
  logic       o_r1 [2];
  logic       o_rv [2];
  logic       o_id [2];
  logic       o_busy [2];
  logic [4:0] o_res [2];

  assign o_r0[0]   = if_k0.req0_ready;
  assign o_r1[0]   = if_k0.req1_ready;
  assign o_rv[0]   = if_k0.rsp_valid;
  assign o_id[0]   = if_k0.rsp_id;
  assign o_busy[0] = if_k0.busy;
  assign o_res[0]  = if_k0.rsp_result;
  assign o_r0[1]   = if_k1.req0_ready;
  assign o_r1[1]   = if_k1.req1_ready;
  assign o_rv[1]   = if_k1.rsp_valid;
  assign o_id[1]   = if_k1.rsp_id;
  assign o_busy[1] = if_k1.busy;
  assign o_res[1]  = if_k1.rsp_result;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per DUT: is an operation in flight, how many edges since its accept,
  // and who won last. Expected {id, result} pairs are queued on accept.
  bit         m_active [2];
  int         m_elapsed [2];
  bit         m_last [2];
  logic [5:0] exp_q0 [$];
  logic [5:0] exp_q1 [$];
  bit         chk_en = 1'b0;
  int         mw;
  int         mon_w;
  logic       mon_rv;
  logic [5:0] ent;

  function automatic int exec_of(input int k);
    return (k == 0) ? EX_K0 : EX_K1;
  endfunction

  function automatic logic [4:0] ref_alu(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0:    r = ia + ib;
      2'd1:    r = (ia - ib + 32) % 32;
      2'd2:    r = ia & ib;
      default: r = ia | ib;
    endcase
    return r[4:0];
  endfunction

  // winner among currently valid ports, -1 if none
  function automatic int pick(input int k);
    if (d_v0[k] && d_v1[k]) begin
`ifdef CALC_ARB_FIXED_PRIO_EN
      return 0;
`else
      return m_last[k] ? 0 : 1;
`endif
    end
    if (d_v0[k]) return 0;
    if (d_v1[k]) return 1;
    return -1;
  endfunction

  // model advances on each edge using the inputs present before it
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_active[k]  = 1'b0;
        m_elapsed[k] = 0;
        m_last[k]    = 1'b1;
        if (k == 0) exp_q0.delete();
        else        exp_q1.delete();
      end else if (!m_active[k]) begin
        mw = pick(k);
        if (mw >= 0) begin
          m_active[k]  = 1'b1;
          m_elapsed[k] = 0;
          m_last[k]    = (mw == 1);
          if (mw == 0) ent = {1'b0, ref_alu(d_op0[k], d_a0[k], d_b0[k])};
          else         ent = {1'b1, ref_alu(d_op1[k], d_a1[k], d_b1[k])};
          if (k == 0) exp_q0.push_back(ent);
          else        exp_q1.push_back(ent);
        end
      end else if (m_elapsed[k] >= exec_of(k)) begin
        if (d_rr[k]) m_active[k] = 1'b0;
      end else begin
        m_elapsed[k]++;
      end
    end
  end

  // per-cycle comparison of DUT outputs against the model, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        mon_w  = (rst || m_active[k]) ? -1 : pick(k);
        mon_rv = m_active[k] && (m_elapsed[k] >= exec_of(k));
        check($sformatf("k%0d_req0_ready", k), o_r0[k], mon_w == 0);
        check($sformatf("k%0d_req1_ready", k), o_r1[k], mon_w == 1);
        check($sformatf("k%0d_busy", k), o_busy[k], m_active[k]);
        check($sformatf("k%0d_rsp_valid", k), o_rv[k], mon_rv);
        if (o_rv[k] && d_rr[k]) begin
          if (k == 0) begin
            check("k0_rsp_expected", exp_q0.size() > 0, 1'b1);
            if (exp_q0.size() > 0) check("k0_rsp_payload", {o_id[0], o_res[0]}, exp_q0.pop_front());
          end else begin
            check("k1_rsp_expected", exp_q1.size() > 0, 1'b1);
            if (exp_q1.size() > 0) check("k1_rsp_payload", {o_id[1], o_res[1]}, exp_q1.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int port, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] op);
    if (port == 0) begin
      d_v0[k] = v; d_a0[k] = a; d_b0[k] = b; d_op0[k] = op;
    end else begin
      d_v1[k] = v; d_a1[k] = a; d_b1[k] = b; d_op1[k] = op;
    end
  endtask

  // wait (bounded) for a ready on the given port; returns at that negedge
  task automatic wait_ready(input int k, input int port, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if ((port == 0) ? o_r0[k] : o_r1[k]) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1'b1);
  endtask

  // wait (bounded) for the DUT to go idle; returns at a negedge
  task automatic drain(input int k);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!o_busy[k]) break;
    end
    check($sformatf("k%0d_drain_idle", k), o_busy[k], 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    int   acc1;
    int   acc2;
    int   rv_at;
    int   seen;
    logic found;
    logic acc0_s [2];
    logic acc1_s [2];
    logic [4:0] exp_res;
    logic       exp_id;

    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, 1'b1, 4'h9, 4'h8, 2'b00);
      set_req(k, 1, 1'b1, 4'hA, 4'h5, 2'b11);
      d_rr[k] = 1'b1;
    end
    rst = 1'b1;

    // reset defaults: two reset cycles with both valids high
    step();
    chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("k%0d_rst_req0_ready", k), o_r0[k], 1'b0);
      check($sformatf("k%0d_rst_req1_ready", k), o_r1[k], 1'b0);
      check($sformatf("k%0d_rst_rsp_valid", k), o_rv[k], 1'b0);
      check($sformatf("k%0d_rst_rsp_result", k), o_res[k], 5'h00);
      check($sformatf("k%0d_rst_rsp_id", k), o_id[k], 1'b0);
      check($sformatf("k%0d_rst_busy", k), o_busy[k], 1'b0);
    end
    step();
    rst = 1'b0;
    set_req(1, 0, 1'b0, 4'h0, 4'h0, 2'b00);
    set_req(1, 1, 1'b0, 4'h0, 4'h0, 2'b00);

    // first accept after reset goes to port 0; single op 9+8
    @(negedge clk);
    check("first_grant_port0", o_r0[0], 1'b1);
    check("first_grant_not_port1", o_r1[0], 1'b0);
    step();
    d_v0[0] = 1'b0;
    d_v1[0] = 1'b0;
    @(negedge clk);
    check("single_exec_no_rsp", o_rv[0], 1'b0);
    @(negedge clk);
    check("single_rsp_valid", o_rv[0], 1'b1);
    check("single_rsp_result", o_res[0], 5'h11);
    check("single_rsp_id", o_id[0], 1'b0);
    @(negedge clk);
    check("single_busy_low_after", o_busy[0], 1'b0);

    // contention from a fresh reset
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 0, 1'b1, 4'h3, 4'h5, 2'b01);
    set_req(0, 1, 1'b1, 4'hA, 4'h5, 2'b11);
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (o_rv[0] && d_rr[0]) begin
`ifdef CALC_ARB_FIXED_PRIO_EN
        exp_id = 1'b0;
`else
        exp_id = (n % 2 == 1);
`endif
        exp_res = exp_id ? 5'h0F : 5'h1E;
        check($sformatf("cont_id_%0d", n), o_id[0], exp_id);
        check($sformatf("cont_result_%0d", n), o_res[0], exp_res);
        n++;
      end
    end
    check("cont_rsp_count", n, 4);
    step();
    d_v0[0] = 1'b0;
    d_v1[0] = 1'b0;
    drain(0);

    // backpressure: RESP held while port 1 waits
    step();
    d_rr[0] = 1'b0;
    set_req(0, 0, 1'b1, 4'h1, 4'h2, 2'b00);
    wait_ready(0, 0, "bp_port0_accept");
    step();
    d_v0[0] = 1'b0;
    set_req(0, 1, 1'b1, 4'h7, 4'h6, 2'b01);
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_rv[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("bp_rsp_arrives", found, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_result_%0d", i), o_res[0], 5'h03);
      check($sformatf("bp_hold_id_%0d", i), o_id[0], 1'b0);
      check($sformatf("bp_no_req1_ready_%0d", i), o_r1[0], 1'b0);
      @(negedge clk);
    end
    step();
    d_rr[0] = 1'b1;
    @(negedge clk);
    check("bp_handshake_valid", o_rv[0], 1'b1);
    check("bp_handshake_no_ready", o_r1[0], 1'b0);
    @(negedge clk);
    check("bp_port1_accept_in_idle", o_r1[0], 1'b1);
    step();
    d_v1[0] = 1'b0;
    drain(0);

    // EXEC_CYCLES = 4: latency and back-to-back spacing
    step();
    set_req(1, 0, 1'b1, 4'hC, 4'hA, 2'b10);
    acc1  = -1;
    acc2  = -1;
    rv_at = -1;
    for (int c = 0; c < 60 && acc2 < 0; c++) begin
      @(negedge clk);
      if (o_r0[1]) begin
        if (acc1 < 0) acc1 = cyc;
        else          acc2 = cyc;
      end
      if (o_rv[1] && rv_at < 0) begin
        rv_at = cyc;
        check("ex4_result", o_res[1], 5'h08);
        check("ex4_id", o_id[1], 1'b0);
      end
    end
    check("ex4_latency", rv_at - (acc1 + 1), EX_K1);
    check("ex4_accept_spacing", acc2 - acc1, EX_K1 + 2);
    step();
    d_v0[1] = 1'b0;
    drain(1);

    // reset during EXEC aborts the operation
    step();
    set_req(1, 0, 1'b1, 4'h5, 4'h4, 2'b11);
    wait_ready(1, 0, "rstmid_accept");
    step();
    d_v0[1] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_rv[1]) seen++;
    end
    check("rstmid_no_response", seen, 0);
    check("rstmid_busy_low", o_busy[1], 1'b0);
    step();
    set_req(1, 0, 1'b1, 4'h6, 4'h3, 2'b00);
    wait_ready(1, 0, "rstmid_reaccept");
    step();
    d_v0[1] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_rv[1]) begin
        found = 1'b1;
        break;
      end
    end
    check("rstmid_after_rsp", found, 1'b1);
    check("rstmid_after_result", o_res[1], 5'h09);
    check("rstmid_after_id", o_id[1], 1'b0);
    drain(1);

    // randomized traffic on both DUTs, with occasional resets
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        acc0_s[k] = o_r0[k];
        acc1_s[k] = o_r1[k];
      end
      step();
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        if (d_v0[k] && !acc0_s[k]) begin
          if ($urandom_range(0, 9) == 0) d_v0[k] = 1'b0;
        end else begin
          set_req(k, 0, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        if (d_v1[k] && !acc1_s[k]) begin
          if ($urandom_range(0, 9) == 0) d_v1[k] = 1'b0;
        end else begin
          set_req(k, 1, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        d_rr[k] = ($urandom_range(0, 3) != 0);
      end
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_v0[k] = 1'b0;
      d_v1[k] = 1'b0;
      d_rr[k] = 1'b1;
    end
    drain(0);
    drain(1);
    check("k0_scoreboard_empty", exp_q0.size(), 0);
    check("k1_scoreboard_empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
